// File: rtl/seq_ka_mult.sv
// seq_ka_mult: sequential digit-serial unsigned multiplier, wD multiplier bits per cycle,
// valid/ready handshake on both sides, full/low/high product selection.
module seq_ka_mult #(
    parameter int wI = 32,
    parameter int wD = 8,
    parameter int wO = 2 * wI
) (
    input  logic          iClk,
    input  logic          iRstn,
    input  logic          iValid,
    output logic          oReady,
    input  logic [wI-1:0] iX,
    input  logic [wI-1:0] iY,
    input  logic [1:0]    iMode,
    output logic          oValid,
    input  logic          iReady,
    output logic [wO-1:0] oO
);
    localparam int N  = wI / wD;
    localparam int wC = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [wI-1:0]   x, y;
    logic [1:0]      mode;
    logic [wO-1:0]   acc, acc_nx, pp, result;
    logic [wD-1:0]   digit;
    logic [wC-1:0]   cnt;
    logic            last;

    assign oReady = (state == IDLE);
    assign oValid = (state == DONE);
    assign last   = (cnt == wC'(N - 1));

    always_ff @(posedge iClk or negedge iRstn)
        if (!iRstn) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE) ? (iValid ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) :
                                     (iReady ? IDLE : DONE);
        digit    = wD'(y >> (cnt * wD));
        pp       = wO'(x) * wO'(digit);
        acc_nx   = acc + (pp << (cnt * wD));
        // mode 11 falls through to the full product
        result   = (mode == 2'b01) ? {{wI{1'b0}}, acc_nx[wI-1:0]} :
                   (mode == 2'b10) ? {{wI{1'b0}}, acc_nx[wO-1:wI]} : acc_nx;
    end

    always_ff @(posedge iClk or negedge iRstn)
        if (!iRstn) begin
            x    <= '0;
            y    <= '0;
            mode <= '0;
            acc  <= '0;
            cnt  <= '0;
            oO   <= '0;
        end else begin
            if (state == IDLE && iValid) begin
                x    <= iX;
                y    <= iY;
                mode <= iMode;
                acc  <= '0;
                cnt  <= '0;
            end
            if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
                if (last) oO <= result;
            end
            if (state == DONE && iReady) oO <= '0;
        end
endmodule
